tone_sequencer: RTL
===================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter TONE_CYCLES, default 25000000, clock cycles each tone sounds (>=1).
REQ-002 SHALL have parameter GAP_CYCLES, default 12500000, silent clock cycles after each tone (>=1).
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset; synchronous to clock, active-low.
REQ-005 SHALL have port start  input  1  request to play a sequence; sampled every cycle.
REQ-006 SHALL have port seq_len  input  5  number of tones, 1..16; values >16 are treated as 16.
REQ-007 SHALL have port seq_data  input  32  packed colors; tone k = seq_data[2k+1:2k].
REQ-008 SHALL have port abort  input  1  stop the sequence; present only with TONE_SEQ_ABORT_EN.
REQ-009 SHALL have port play_audio  output  1  one-cycle strobe telling the audio block to latch color/on_off.
REQ-010 SHALL have port color  output  2  color of the current tone.
REQ-011 SHALL have port on_off  output  1  1 = tone sounding, 0 = silent.
REQ-012 SHALL have port busy  output  1  high while a sequence is in progress.
REQ-013 SHALL have port tone_idx  output  4  index of the current tone.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the sequence completes normally.

Function
REQ-015 SHALL implement the states IDLE, TONE and GAP; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 with seq_len!=0 SHALL, at that edge, capture seq_data and the clamped length, and set idx=0, cnt=0, state=TONE, busy=1, play_audio=1, on_off=1, color=seq_data[1:0].
REQ-017 start while busy, or with seq_len=0, SHALL be ignored and change no state.
REQ-018 Latency from start to the first play_audio SHALL be exactly 1 cycle.
REQ-019 TONE SHALL last TONE_CYCLES cycles; at the edge where cnt==TONE_CYCLES-1, the block SHALL set state=GAP, cnt=0, play_audio=1, on_off=0, and leave color unchanged.
REQ-020 GAP SHALL last GAP_CYCLES cycles; at its final edge with idx<len-1, it SHALL increment idx, set state=TONE, play_audio=1, on_off=1, and set color to the next captured entry.
REQ-021 At the final GAP edge with idx==len-1, the block SHALL set state=IDLE, busy=0, done=1 for one cycle; tone_idx SHALL hold its last value.
REQ-022 play_audio SHALL be high only on the cycles defined in REQ-016, REQ-019, REQ-020, REQ-029 and REQ-031; otherwise 0.
REQ-023 The cycle counter SHALL be 25 bits wide and SHALL never exceed max(TONE_CYCLES,GAP_CYCLES)-1.
REQ-024 Captured seq_data and len SHALL be immune to input changes while busy.
REQ-025 Period per tone SHALL be exactly TONE_CYCLES+GAP_CYCLES cycles.

Reset
REQ-026 While resetn=0 at an edge, the block SHALL set state=IDLE, and play_audio, on_off, busy, done, color, tone_idx and cnt SHALL all be 0.
REQ-027 Reset mid-sequence SHALL discard the sequence without asserting done.
REQ-028 On the first edge with resetn=1 after reset, the block SHALL set a silence flag.
REQ-029 On the cycle after the flag is set, the block SHALL output play_audio=1 with on_off=0, so that the downstream latch is silenced; start on that edge SHALL be ignored.

Configuration
REQ-030 Macro TONE_SEQ_ABORT_EN SHALL gate the abort port and its logic.
REQ-031 With TONE_SEQ_ABORT_EN defined, abort=1 while busy SHALL, at that edge, set state=IDLE, busy=0, play_audio=1, on_off=0; done SHALL stay 0.
REQ-032 With TONE_SEQ_ABORT_EN defined, abort=1 in IDLE SHALL have no effect, and abort SHALL take priority over any TONE or GAP transition on the same edge.
REQ-033 Without TONE_SEQ_ABORT_EN, the abort port SHALL be absent and a sequence SHALL stop only by completion or reset.

Verification (TONE_CYCLES=4, GAP_CYCLES=2; cycle 0 = start edge)
REQ-034 Bench SHALL check: seq_data=32'hE4, seq_len=4, start pulse -> play_audio at cycles 1,5,7,11,13,17,19,23; color 0,1,2,3 at cycles 1,7,13,19; on_off=0 at 5,11,17,23; done only at cycle 25; busy for cycles 1..24.
REQ-035 Bench SHALL check: seq_len=0 with start -> no play_audio, busy stays 0; seq_len=20, seq_data=all ones -> 16 tones of color 3, done at cycle 97.
REQ-036 Bench SHALL check: start re-pulsed at cycle 3 with different seq_data -> output identical to REQ-034 stream.
REQ-037 Bench SHALL check: resetn=0 at cycle 8, released at cycle 10 -> all outputs 0 during reset; single play_audio with on_off=0 on the first cycle after release; no done.
REQ-038 Bench SHALL check, with TONE_SEQ_ABORT_EN: abort at cycle 9 -> cycle 10 shows play_audio=1, on_off=0, busy=0, done=0; a new start at cycle 12 is accepted.

Source files
------------

// File: rtl/tone_sequencer.sv
// Plays up to sixteen 2-bit colour tones, each followed by a silent gap, driving an audio latch.
// Defining TONE_SEQ_ABORT_EN adds the abort input that cuts a running sequence short.
module tone_sequencer #(
    parameter int unsigned TONE_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 12500000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [4:0]  seq_len,
    input  logic [31:0] seq_data,
`ifdef TONE_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic        play_audio,
    output logic [1:0]  color,
    output logic        on_off,
    output logic        busy,
    output logic [3:0]  tone_idx,
    output logic        done
);

    localparam logic [24:0] ToneLast = 25'(TONE_CYCLES - 1);
    localparam logic [24:0] GapLast  = 25'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StTone,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  last_q, last_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  color_q, color_d;
    logic        on_q, on_d;
    logic        play_q, play_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        silenced_q, silenced_d;

    logic        abort_req;
    logic [3:0]  next_idx;
    logic [3:0]  len_last;

`ifdef TONE_SEQ_ABORT_EN
    assign abort_req = abort && (state_q != StIdle);
`else
    assign abort_req = 1'b0;
`endif

    assign next_idx = idx_q + 4'd1;
    // Only used when seq_len is nonzero; lengths above 16 saturate to index 15
    assign len_last = (seq_len > 5'd16) ? 4'd15 : 4'(seq_len - 5'd1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        last_d     = last_q;
        data_d     = data_q;
        color_d    = color_q;
        on_d       = on_q;
        busy_d     = busy_q;
        play_d     = 1'b0;
        done_d     = 1'b0;
        silenced_d = 1'b1;

        if (!silenced_q) begin
            // First edge out of reset: force the downstream latch silent, start is ignored
            play_d = 1'b1;
            on_d   = 1'b0;
        end else if (abort_req) begin
            state_d = StIdle;
            cnt_d   = '0;
            busy_d  = 1'b0;
            play_d  = 1'b1;
            on_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (seq_len != 5'd0)) begin
                        state_d = StTone;
                        cnt_d   = '0;
                        idx_d   = '0;
                        last_d  = len_last;
                        data_d  = seq_data;
                        color_d = seq_data[1:0];
                        on_d    = 1'b1;
                        play_d  = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                StTone: begin
                    if (cnt_q == ToneLast) begin
                        state_d = StGap;
                        cnt_d   = '0;
                        play_d  = 1'b1;
                        on_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 25'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_d = '0;
                        if (idx_q == last_q) begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StTone;
                            idx_d   = next_idx;
                            color_d = data_q[{next_idx, 1'b0} +: 2];
                            on_d    = 1'b1;
                            play_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 25'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            data_q     <= '0;
            color_q    <= '0;
            on_q       <= 1'b0;
            play_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            silenced_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            data_q     <= data_d;
            color_q    <= color_d;
            on_q       <= on_d;
            play_q     <= play_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            silenced_q <= silenced_d;
        end
    end

    assign play_audio = play_q;
    assign color      = color_q;
    assign on_off     = on_q;
    assign busy       = busy_q;
    assign tone_idx   = idx_q;
    assign done       = done_q;

endmodule
